// File: rtl/cpu7_csr_rwctl.sv
// rtl/cpu7_csr_rwctl.sv - CSR micro-op sequencer: read old value, optional masked write, return old value.
module cpu7_csr_rwctl #(
    parameter int GRLEN   = 32,
    parameter int CSR_BIT = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [CSR_BIT-1:0] req_num,
    input  logic [GRLEN-1:0]   req_wdata,
    input  logic [GRLEN-1:0]   req_mask,
    input  logic [1:0]         req_plv,
    input  logic               flush,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [GRLEN-1:0]   rsp_rdata,
    output logic               rsp_ipe,
    output logic               rsp_ine,
    output logic [CSR_BIT-1:0] csr_raddr,
    input  logic [GRLEN-1:0]   csr_rdata,
    output logic [CSR_BIT-1:0] csr_waddr,
    output logic [GRLEN-1:0]   csr_wdata,
    output logic [GRLEN-1:0]   csr_mask,
    output logic               csr_wen
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_CSRRD = 2'b00;
    localparam logic [1:0] OP_CSRWR = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [CSR_BIT-1:0] r_num;
    logic [GRLEN-1:0]   r_wdata;
    logic [GRLEN-1:0]   r_mask;
    logic [GRLEN-1:0]   r_rdata;
    logic               r_ipe;
    logic               r_ine;
    logic               r_drop;
    logic               w_accept;
    logic               w_fault;

    assign w_accept = (r_state == S_IDLE) & req_valid & ~flush;
    assign w_fault  = (req_plv != 2'b00) | (req_op == OP_RSVD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_fault ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_op == OP_CSRRD) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = S_RESP;
            S_RESP: begin
                if (rsp_ready | flush | r_drop) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The old value is captured in READ so the response never sees the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_num   <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
            r_ipe   <= 1'b0;
            r_ine   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= req_op;
                r_num   <= req_num;
                r_wdata <= req_wdata;
                r_mask  <= req_mask;
                r_rdata <= '0;
                r_ipe   <= (req_plv != 2'b00);
                r_ine   <= (req_plv == 2'b00) & (req_op == OP_RSVD);
                r_drop  <= 1'b0;
            end
            if (r_state == S_READ) begin
                r_rdata <= csr_rdata;
            end
            if ((r_state == S_WRITE) && flush) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_ipe   = 1'b0;
        rsp_ine   = 1'b0;
        csr_raddr = '0;
        csr_waddr = '0;
        csr_wdata = '0;
        csr_mask  = '0;
        csr_wen   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: req_ready = 1'b1;
                S_READ: csr_raddr = r_num;
                S_WRITE: begin
                    csr_wen   = 1'b1;
                    csr_waddr = r_num;
                    csr_wdata = r_wdata;
                    csr_mask  = (r_op == OP_CSRWR) ? {GRLEN{1'b1}} : r_mask;
                end
                S_RESP: begin
                    rsp_valid = ~r_drop;
                    rsp_rdata = r_rdata;
                    rsp_ipe   = r_ipe;
                    rsp_ine   = r_ine;
                end
                default: req_ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu7_csr_rwctl.sv
// tb/tb_cpu7_csr_rwctl.sv - scoreboard bench for cpu7_csr_rwctl with a small CSR file model.
module tb_cpu7_csr_rwctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [13:0] req_num;
    logic [31:0] req_wdata;
    logic [31:0] req_mask;
    logic [1:0]  req_plv;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_ipe;
    logic        rsp_ine;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_mask;
    logic        csr_wen;

    typedef struct {
        logic [31:0] rdata;
        logic        ipe;
        logic        ine;
    } rsp_t;

    rsp_t        sb_q[$];
    rsp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic        mem_init;
    logic [31:0] csr_mem [0:15];
    logic [31:0] ref_mem [0:15];

    always #5 clk = ~clk;

    cpu7_csr_rwctl #(.GRLEN(32), .CSR_BIT(14)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_num(req_num), .req_wdata(req_wdata), .req_mask(req_mask),
        .req_plv(req_plv), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_ipe(rsp_ipe), .rsp_ine(rsp_ine),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata), .csr_mask(csr_mask), .csr_wen(csr_wen)
    );

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h0000_0004;
            6:       return 32'h0000_1234;
            12:      return 32'h5A5A_1234;
            default: return 32'h0;
        endcase
    endfunction

    // CSR file: 16 implemented registers, the rest read 0 and ignore writes.
    assign csr_rdata = (csr_raddr < 14'd16) ? csr_mem[csr_raddr[3:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) csr_mem[i] <= init_val(i);
        end else if (csr_wen && csr_waddr < 14'd16) begin
            csr_mem[csr_waddr[3:0]] <= (csr_mem[csr_waddr[3:0]] & ~csr_mask) | (csr_wdata & csr_mask);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_ipe", 32'(rsp_ipe), 32'(mon_e.ipe));
                check("rsp_ine", 32'(rsp_ine), 32'(mon_e.ine));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [13:0] num, input logic [31:0] wd,
                        input logic [31:0] mk, input logic [1:0] plv, input bit push, input bit commit);
        rsp_t        e;
        logic [31:0] m;
        check("req_ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_num   = num;
        req_wdata = wd;
        req_mask  = mk;
        req_plv   = plv;
        e.ipe   = (plv != 2'b00);
        e.ine   = (plv == 2'b00) && (op == 2'b11);
        e.rdata = (e.ipe || e.ine) ? 32'h0 : ref_mem[num[3:0]];
        if (push) sb_q.push_back(e);
        if (commit && !e.ipe && !e.ine && op != 2'b00) begin
            m = (op == 2'b01) ? 32'hFFFF_FFFF : mk;
            ref_mem[num[3:0]] = (ref_mem[num[3:0]] & ~m) | (wd & m);
        end
        step();
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_num   = '0;
        req_wdata = '0;
        req_mask  = '0;
        req_plv   = 2'b00;
    endtask

    task automatic finish_op();
        for (int i = 0; i < 40 && !req_ready; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        rsp_ready = 1'b1;
        check("op_done", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_num = '0; req_wdata = '0;
        req_mask = '0; req_plv = 2'b00; flush = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        step();
        mem_init = 1'b0;
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_csr_wen", 32'(csr_wen), 32'd0);
        check("rst_csr_mask", csr_mask, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);

        // csrrd
        send(2'b00, 14'h0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1);
        check("rd_raddr", 32'(csr_raddr), 32'h0);
        check("rd_rsp_n1", 32'(rsp_valid), 32'd0);
        step();
        check("rd_rsp_n2", 32'(rsp_valid), 32'd1);
        check("rd_rdata_n2", rsp_rdata, 32'h4);
        check("rd_wen", 32'(csr_wen), 32'd0);
        step();
        check("rd_idle", 32'(req_ready), 32'd1);

        // csrwr
        send(2'b01, 14'h6, 32'h1C00_0100, 32'h0, 2'd0, 1'b1, 1'b1);
        check("wr_raddr", 32'(csr_raddr), 32'h6);
        check("wr_wen_n1", 32'(csr_wen), 32'd0);
        step();
        check("wr_wen_n2", 32'(csr_wen), 32'd1);
        check("wr_waddr", 32'(csr_waddr), 32'h6);
        check("wr_wdata", csr_wdata, 32'h1C00_0100);
        check("wr_mask", csr_mask, 32'hFFFF_FFFF);
        check("wr_rsp_n2", 32'(rsp_valid), 32'd0);
        step();
        check("wr_rsp_n3", 32'(rsp_valid), 32'd1);
        check("wr_rdata_n3", rsp_rdata, 32'h1234);
        step();

        // csrxchg
        send(2'b10, 14'hC, 32'hFFFF_FFFF, 32'h0000_FF00, 2'd0, 1'b1, 1'b1);
        step();
        check("xchg_wen", 32'(csr_wen), 32'd1);
        check("xchg_mask", csr_mask, 32'h0000_FF00);
        step();
        check("xchg_rdata", rsp_rdata, 32'h5A5A_1234);
        step();

        // privilege and reserved-op faults
        send(2'b01, 14'h6, 32'h1111_2222, 32'h0, 2'd3, 1'b1, 1'b1);
        check("ipe_valid", 32'(rsp_valid), 32'd1);
        check("ipe_flag", 32'(rsp_ipe), 32'd1);
        check("ipe_rdata", rsp_rdata, 32'h0);
        check("ipe_raddr", 32'(csr_raddr), 32'h0);
        check("ipe_wen", 32'(csr_wen), 32'd0);
        step();
        check("ipe_wen_after", 32'(csr_wen), 32'd0);
        send(2'b11, 14'h6, 32'h1111_2222, 32'h0, 2'd0, 1'b1, 1'b1);
        check("ine_valid", 32'(rsp_valid), 32'd1);
        check("ine_flag", 32'(rsp_ine), 32'd1);
        step();

        // flush in READ cancels everything
        send(2'b01, 14'h6, 32'hDEAD_BEEF, 32'h0, 2'd0, 1'b0, 1'b0);
        check("frd_raddr", 32'(csr_raddr), 32'h6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("frd_ready", 32'(req_ready), 32'd1);
        check("frd_wen", 32'(csr_wen), 32'd0);
        check("frd_rsp", 32'(rsp_valid), 32'd0);

        // flush in WRITE commits the write but drops the response
        send(2'b01, 14'h6, 32'hAAAA_5555, 32'h0, 2'd0, 1'b0, 1'b1);
        step();
        check("fwr_wen", 32'(csr_wen), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fwr_rsp_n3", 32'(rsp_valid), 32'd0);
        step();
        check("fwr_rsp_n4", 32'(rsp_valid), 32'd0);
        check("fwr_ready", 32'(req_ready), 32'd1);

        // response backpressure, then back-to-back accept
        rsp_ready = 1'b0;
        send(2'b00, 14'h6, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hAAAA_5555);
            check("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        send(2'b00, 14'h0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1);
        step();
        check("b2b_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rdata", rsp_rdata, 32'h4);
        step();

        // reset in the WRITE cycle suppresses the write strobe
        send(2'b01, 14'hC, 32'h1111_1111, 32'h0, 2'd0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("rstw_wen", 32'(csr_wen), 32'd0);
        check("rstw_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rstw_idle", 32'(req_ready), 32'd1);
        check("rstw_rsp", 32'(rsp_valid), 32'd0);

        for (int n = 0; n < 24; n++) begin
            logic [1:0] r_plv;
            r_plv = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            send(2'($urandom_range(0, 3)), 14'($urandom_range(0, 15)), $urandom, $urandom,
                 r_plv, 1'b1, 1'b1);
            finish_op();
        end

        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) check("csr_final", csr_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
